// File: rtl/hdlc_cmd_scheduler.sv
// hdlc_cmd_scheduler: round-robin arbiter and frame sequencer sharing one HDLC command serialiser.
// Optional HDLC_SCHED_URGENT_EN: requester 0 pre-empts round-robin and leaves the pointer untouched.
module hdlc_cmd_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 512,
  localparam int GID_W         = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [1:0]            tx_clk_cnt,
  output logic                  tx_rstn,
  output logic [31:0]           tx_command_data,
  input  logic                  tx_finish,
  output logic                  busy,
  output logic [GID_W-1:0]      grant_id,
  output logic                  done,
  output logic                  timeout_err
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, ABORT, GAP} state_t;

  state_t           state, state_nxt;
  logic [GID_W-1:0] ptr, winner, idx;
  logic             found, accept, wd_expire, gap_end;
  logic [WD_W-1:0]  wdog;
  logic [7:0]       gap_cnt;

  // Search starts one past the last round-robin winner so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
`ifdef HDLC_SCHED_URGENT_EN
    if (req_valid[0]) found = 1'b1;
`endif
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign accept    = rstn && (state == IDLE) && found;
  assign wd_expire = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign gap_end   = (gap_cnt == 8'(GAP_CYCLES));
  assign busy      = (state != IDLE);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Finish beats the watchdog when both land in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN: begin
        if (tx_finish)      state_nxt = GAP;
        else if (wd_expire) state_nxt = ABORT;
      end
      ABORT:   state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr             <= GID_W'(NUM_REQ - 1);
      tx_clk_cnt      <= '0;
      tx_rstn         <= 1'b0;
      tx_command_data <= '0;
      grant_id        <= '0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
      wdog            <= '0;
      gap_cnt         <= '0;
    end else begin
      tx_clk_cnt  <= tx_clk_cnt + 2'd1;
      // Registered from next state: high exactly while in RUN, so only RUN entry makes a rising edge.
      tx_rstn     <= (state_nxt == RUN);
      wdog        <= (state == RUN) ? wdog + WD_W'(1) : '0;
      gap_cnt     <= (state == GAP) ? gap_cnt + 8'd1 : '0;
      done        <= (state == RUN) && tx_finish;
      timeout_err <= (state == RUN) && !tx_finish && wd_expire;
      if (accept) begin
        tx_command_data <= req_data[32*int'(winner) +: 32];
        grant_id        <= winner;
`ifdef HDLC_SCHED_URGENT_EN
        if (winner != '0) ptr <= winner;
`else
        ptr <= winner;
`endif
      end
    end
  end

endmodule

// File: tb/tb_hdlc_cmd_scheduler.sv
`timescale 1ns/1ps
// Randomised scoreboard bench: a transaction-level model predicts accepts, done/timeout pulses and
// the tx_rstn/busy windows; a negedge monitor compares the DUT against those predictions.
module tb_hdlc_cmd_scheduler;
  localparam int NR  = 4;
  localparam int GAP = 3;
  localparam int TO  = 256;
  localparam int GW  = 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NR-1:0]    req_valid, req_ready;
  logic [32*NR-1:0] req_data;
  logic [1:0]       tx_clk_cnt;
  logic             tx_rstn, tx_finish, busy, done, timeout_err;
  logic [31:0]      tx_command_data;
  logic [GW-1:0]    grant_id;

  hdlc_cmd_scheduler #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_clk_cnt(tx_clk_cnt), .tx_rstn(tx_rstn), .tx_command_data(tx_command_data),
    .tx_finish(tx_finish), .busy(busy), .grant_id(grant_id), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [31:0] e1; logic [31:0] e2;} ev_t;
  ev_t sbq[3][$];   // 0: accepts, 1: done pulses, 2: timeout pulses

  int vectors = 0, errors = 0;
  int cyc = 0;
  bit mon_en = 0;
  int run_lo = 1, run_hi = 0, busy_lo = 1, busy_hi = 0;

  int free_at = 0, fin_at = -1, ptr_m = NR - 1, force_n = -1, drop_w = -1;
  bit [NR-1:0] vld;
  logic [31:0] dat [NR];
  int p_arr = 0, p_wd = 0, p_to = 0;
  bit gen_en = 0;

  task automatic bad(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    errors++;
    if (errors <= 30) $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) bad(name, act, exp);
    else vectors++;
  endtask

  task automatic sb(int k, bit seen, string name, logic [31:0] a1, logic [31:0] a2, bit two);
    ev_t e;
    if (seen) begin
      if (sbq[k].size() == 0) bad({name, " unexpected"}, a1, 0);
      else begin
        e = sbq[k].pop_front();
        chk({name, " cycle"}, 32'(cyc), 32'(e.cyc));
        chk({name, " id"}, a1, e.e1);
        if (two) chk({name, " data"}, a2, e.e2);
      end
    end else if (sbq[k].size() != 0 && sbq[k][0].cyc <= cyc) begin
      e = sbq[k].pop_front();
      bad({name, " missing"}, 0, 32'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("tx_clk_cnt", 32'(tx_clk_cnt), 32'(cyc % 4));
      chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      chk("tx_rstn", 32'(tx_rstn), 32'(cyc >= run_lo && cyc <= run_hi));
      sb(0, |req_ready, "accept", 32'(req_ready), 32'd0, 1'b0);
      sb(1, done, "done", 32'(grant_id), tx_command_data, 1'b1);
      sb(2, timeout_err, "timeout", 32'(grant_id), tx_command_data, 1'b1);
    end
  end

  // Next requester after the last round-robin winner, optionally with requester 0 first.
  function automatic int pick();
`ifdef HDLC_SCHED_URGENT_EN
    if (vld[0]) return 0;
`endif
    for (int k = 1; k <= NR; k++)
      if (vld[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
    return -1;
  endfunction

  task automatic body();
    int w, n;
    bit spur;
    if (drop_w >= 0) begin vld[drop_w] = 1'b0; drop_w = -1; end
    for (int i = 0; i < NR; i++) begin
      if (!vld[i] && gen_en && $urandom_range(99) < p_arr) begin vld[i] = 1'b1; dat[i] = $urandom; end
      else if (vld[i] && $urandom_range(99) < p_wd) vld[i] = 1'b0;
    end
    if (cyc >= free_at && vld != 0) begin
      w = pick();
      sbq[0].push_back('{cyc, 32'd1 << w, 32'd0});
      if (force_n >= 0) begin n = force_n; force_n = -1; end
      else if ($urandom_range(99) < p_to) n = TO + $urandom_range(0, 3);
      else if ($urandom_range(99) < 5) n = TO - 1;
      else n = $urandom_range(0, 40);
      run_lo  = cyc + 2;
      busy_lo = cyc + 1;
      fin_at  = cyc + 2 + n;
      if (n <= TO - 1) begin
        run_hi  = cyc + 2 + n;
        free_at = cyc + n + GAP + 4;
        sbq[1].push_back('{cyc + 3 + n, 32'(w), dat[w]});
      end else begin
        run_hi  = cyc + 1 + TO;
        free_at = cyc + TO + GAP + 4;
        sbq[2].push_back('{cyc + 2 + TO, 32'(w), dat[w]});
      end
      busy_hi = free_at - 1;
`ifdef HDLC_SCHED_URGENT_EN
      if (w != 0) ptr_m = w;
`else
      ptr_m = w;
`endif
      drop_w = w;
    end
    spur = (cyc < run_lo || cyc > run_hi) && ($urandom_range(99) < 4);
    tx_finish = (cyc == fin_at) || spur;
    req_valid = vld;
    for (int i = 0; i < NR; i++) req_data[32*i +: 32] = dat[i];
  endtask

  task automatic run(int n);
    repeat (n) begin
      body();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_reset();
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst tx_clk_cnt", 32'(tx_clk_cnt), 0);
    chk("rst tx_rstn", 32'(tx_rstn), 0);
    chk("rst tx_command_data", tx_command_data, 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst grant_id", 32'(grant_id), 0);
    chk("rst done", 32'(done), 0);
    chk("rst timeout_err", 32'(timeout_err), 0);
  endtask

  task automatic release_reset();
    for (int k = 0; k < 3; k++) sbq[k].delete();
    ptr_m = NR - 1; free_at = 0; fin_at = -1; force_n = -1; drop_w = -1;
    run_lo = 1; run_hi = 0; busy_lo = 1; busy_hi = 0;
    rstn = 1'b1;
    cyc = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    vld = '0;
    for (int i = 0; i < NR; i++) dat[i] = '0;
    req_valid = '0; req_data = '0; tx_finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'b0101;
    #1;
    check_reset();

    // single requester 0 with a known word
    vld[0] = 1'b1; dat[0] = 32'hDEADBEEF; force_n = 20;
    release_reset();
    force_n = 20;
    run(60);

    // all requesters held continuously
    vld = '1;
    for (int i = 0; i < NR; i++) dat[i] = $urandom;
    gen_en = 1; p_arr = 100; p_wd = 0; p_to = 0;
    run(400);

    // mixed traffic with withdrawals, watchdog expiries and stray finishes
    p_arr = 25; p_wd = 3; p_to = 6;
    run(6000);

    // reset deep inside a long frame
    gen_en = 0; p_wd = 0;
    for (int k = 0; k < 600 && cyc < free_at; k++) run(1);
    vld[2] = 1'b1; dat[2] = $urandom; force_n = 150;
    run(41);
    mon_en = 1'b0;
    vld = '1;
    req_valid = vld;
    tx_finish = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    for (int i = 0; i < NR; i++) dat[i] = $urandom;
    release_reset();
    gen_en = 1; p_arr = 20; p_wd = 2; p_to = 3;
    run(1500);

    // drain
    gen_en = 0; p_wd = 0;
    begin
      int k;
      for (k = 0; k < 3000 && !(vld == 0 && cyc > free_at + 2); k++) run(1);
      if (k == 3000) bad("drain timeout", 32'(vld), 0);
    end
    run(3);
    mon_en = 1'b0;
    for (int k = 0; k < 3; k++)
      if (sbq[k].size() != 0) bad("leftover expected events", 32'(sbq[k].size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
